axis_tx_downsizer: RTL and testbench

AXIS_TX_DOWNSIZER -- requirements
Module: axis_tx_downsizer

---
 rtl/eth_axis_pkg.sv | 13 +
 rtl/axis_keep_scan.sv | 23 ++
 rtl/axis_tx_downsizer.sv | 203 ++++++++++++++++++++
 tb/tb_axis_tx_downsizer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_axis_pkg.sv
// Shared constants and types for the Ethernet AXI-Stream datapath.
// Byte width, tuser error bit position and the downsizer state enum.
package eth_axis_pkg;

  localparam int BYTE_W       = 8;
  localparam int USER_ERR_BIT = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/axis_keep_scan.sv
// Combinational lowest-set-bit finder over a keep mask.
// Ports: mask in; idx (lowest set lane), found (any set), last (one set).
module axis_keep_scan #(
  parameter int KW = 8,
  parameter int IW = (KW > 1) ? $clog2(KW) : 1
) (
  input  logic [KW-1:0] mask,
  output logic [IW-1:0] idx,
  output logic          found,
  output logic          last
);

  always_comb begin
    idx   = '0;
    found = |mask;
    // Scan downward so the lowest set lane writes last and wins.
    for (int i = KW - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
    last = found && ((mask & (mask - KW'(1))) == '0);
  end

endmodule

// File: rtl/axis_tx_downsizer.sv
// Wide AXI-Stream TX beats to a byte stream for the GMII transmitter.
// Ports: aclk/aresetn, s_axis_* wide input, m_axis_* byte out, error_null_last.
module axis_tx_downsizer
  import eth_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [BYTE_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  error_null_last
);

  localparam int IW = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] rem_q, rem_d;
  logic                  last_q, last_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  err_q, err_d;
  logic [BYTE_W-1:0]     odata_q, odata_d;
  logic                  ovalid_q, ovalid_d;
  logic                  olast_q, olast_d;
  logic [USER_WIDTH-1:0] ouser_q, ouser_d;
  logic                  null_q, null_d;
  logic                  run_q, run_d;

  logic                  s_ready;
  logic                  load;
  logic                  use_new;
  logic                  take;
  logic [KEEP_WIDTH-1:0] scan_mask;
  logic [IW-1:0]         scan_idx;
  logic                  scan_found;
  logic                  scan_last;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_last;
  logic [USER_WIDTH-1:0] src_user;
  logic                  err_acc;
  logic                  pick_last;
  logic [BYTE_W-1:0]     pick;
  logic [USER_WIDTH-1:0] eop_user;
  logic [USER_WIDTH-1:0] null_user;

  // run_q keeps tready low while in reset and raises it on the first edge.
  assign s_ready = run_q &
    ((state_q == IDLE) | ((rem_q == '0) & m_axis_tready));
  assign load    = s_axis_tvalid & s_ready;

  // The held beat is exhausted once rem_q is empty: the next pick
  // comes from the incoming beat instead.
  assign use_new   = (state_q == IDLE) | (rem_q == '0);
  assign scan_mask = use_new ? s_axis_tkeep : rem_q;
  assign src_data  = use_new ? s_axis_tdata : data_q;
  assign src_last  = use_new ? s_axis_tlast : last_q;
  assign src_user  = use_new ? s_axis_tuser : user_q;
  assign err_acc   = use_new ?
    (err_q | s_axis_tuser[USER_ERR_BIT]) : err_q;
  assign pick_last = src_last & scan_last;

  axis_keep_scan #(
    .KW (KEEP_WIDTH),
    .IW (IW)
  ) u_scan (
    .mask  (scan_mask),
    .idx   (scan_idx),
    .found (scan_found),
    .last  (scan_last)
  );

  always_comb begin
    pick      = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (scan_idx == IW'(i)) pick = src_data[i*BYTE_W +: BYTE_W];
    end
    eop_user  = src_user;
    eop_user[USER_ERR_BIT]  = err_acc;
    null_user = src_user;
    null_user[USER_ERR_BIT] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    last_d   = last_q;
    user_d   = user_q;
    err_d    = err_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    ouser_d  = ouser_q;
    null_d   = 1'b0;
    run_d    = 1'b1;
    take     = 1'b0;

    unique case (state_q)
      IDLE: take = load;
      SHIFT: begin
        if (m_axis_tready) begin
          if ((rem_q != '0) || load) begin
            take = 1'b1;
          end else begin
            state_d  = IDLE;
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
            ouser_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      if (use_new) begin
        data_d = s_axis_tdata;
        last_d = s_axis_tlast;
        user_d = s_axis_tuser;
        err_d  = err_acc;
      end
      unique case (1'b1)
        scan_found: begin
          state_d  = SHIFT;
          ovalid_d = 1'b1;
          odata_d  = pick;
          olast_d  = pick_last;
          ouser_d  = pick_last ? eop_user : '0;
          rem_d    = scan_mask & ~(KEEP_WIDTH'(1) << scan_idx);
          if (pick_last) err_d = 1'b0;
        end
        (!scan_found && src_last): begin
          // Empty closing beat: still terminate the frame, flagged bad.
          state_d  = SHIFT;
          ovalid_d = 1'b1;
          odata_d  = '0;
          olast_d  = 1'b1;
          ouser_d  = null_user;
          rem_d    = '0;
          err_d    = 1'b0;
          null_d   = 1'b1;
        end
        default: begin
          state_d  = IDLE;
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
          ouser_d  = '0;
          rem_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      last_q   <= 1'b0;
      user_q   <= '0;
      err_q    <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      ouser_q  <= '0;
      null_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      last_q   <= last_d;
      user_q   <= user_d;
      err_q    <= err_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      ouser_q  <= ouser_d;
      null_q   <= null_d;
      run_q    <= run_d;
    end
  end

  assign s_axis_tready   = s_ready;
  assign m_axis_tdata    = odata_q;
  assign m_axis_tvalid   = ovalid_q;
  assign m_axis_tlast    = olast_q;
  assign m_axis_tuser    = ouser_q;
  assign error_null_last = null_q;

endmodule

// File: tb/tb_axis_tx_downsizer.sv
// Randomized and directed bench for axis_tx_downsizer with a queue model.
// Model expands each accepted beat into its expected byte sequence.
module tb_axis_tx_downsizer;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [UW-1:0] s_tuser = '0;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic          err_null;

  always #5 aclk = ~aclk;

  axis_tx_downsizer #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .USER_WIDTH (UW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser    (s_tuser),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .m_axis_tuser    (m_tuser),
    .error_null_last (err_null)
  );

  typedef struct {
    logic [7:0]    d;
    logic          l;
    logic [UW-1:0] u;
  } ob_t;

  ob_t  exp_q[$];
  ob_t  log_q[$];
  int   checks = 0;
  int   failures = 0;
  logic model_err = 1'b0;
  logic exp_null = 1'b0;
  int   null_seen = 0;
  int   rmode = 0;
  logic stall_v = 1'b0;
  logic [7+1+UW:0] stall_snap = '0;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Expected bytes for one accepted beat: kept lanes in ascending order.
  task automatic model_beat(input logic [DW-1:0] d,
                            input logic [KW-1:0] k,
                            input logic l,
                            input logic [UW-1:0] u);
    int  lastk;
    ob_t e;
    lastk = -1;
    model_err = model_err | u[0];
    for (int i = 0; i < KW; i++) if (k[i]) lastk = i;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) begin
        e.d = d[i*8 +: 8];
        e.l = l && (i == lastk);
        e.u = e.l ? {u[UW-1:1], model_err} : '0;
        exp_q.push_back(e);
      end
    end
    if (lastk < 0 && l) begin
      e.d = 8'h00;
      e.l = 1'b1;
      e.u = {u[UW-1:1], 1'b1};
      exp_q.push_back(e);
    end
    if (l) model_err = 1'b0;
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_v   = 1'b0;
      exp_null  = 1'b0;
      model_err = 1'b0;
      exp_q.delete();
    end else begin
      ob_t e;
      ob_t a;
      check("null_pulse", 64'(err_null), 64'(exp_null));
      if (err_null) null_seen++;
      check("valid", 64'(m_tvalid), 64'(exp_q.size() != 0));
      if (stall_v) begin
        check("stall_hold", 64'({m_tdata, m_tlast, m_tuser}),
              64'(stall_snap));
      end
      stall_v    = m_tvalid && !m_tready;
      stall_snap = {m_tdata, m_tlast, m_tuser};
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("byte", 64'(m_tdata), 64'(e.d));
        check("last", 64'(m_tlast), 64'(e.l));
        check("user", 64'(m_tuser), 64'(e.u));
        a.d = m_tdata;
        a.l = m_tlast;
        a.u = m_tuser;
        log_q.push_back(a);
      end
      exp_null = 1'b0;
      if (s_tvalid && s_tready) begin
        model_beat(s_tdata, s_tkeep, s_tlast, s_tuser);
        exp_null = (s_tkeep == '0) && s_tlast;
      end
    end
  end

  initial begin
    logic [3:0] pat;
    int         pi;
    pat = 4'b1001;
    pi  = 0;
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0: m_tready = 1'b1;
        1: m_tready = 1'($urandom_range(0, 1));
        2: begin
          m_tready = pat[pi % 4];
          pi++;
        end
        default: m_tready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic [UW-1:0] u);
    int n;
    n = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 64'(n), 64'(0));
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    s_tvalid = 1'b0;
    forever begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !m_tvalid) break;
      n++;
      if (n > 5000) begin
        check("drain_timeout", 64'(n), 64'(0));
        break;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int ns;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_outs", 64'({m_tdata, m_tlast, m_tuser, err_null}), 64'(0));
    @(negedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("tready_after_rst", 64'(s_tready), 64'(1));

    // Single full beat.
    log_q.delete();
    send(64'h0807060504030201, 8'hFF, 1'b1, 2'b00);
    drain();
    check("t1_len", 64'(log_q.size()), 64'(8));
    for (int i = 0; i < log_q.size(); i++) begin
      check("t1_data", 64'(log_q[i].d), 64'(i + 1));
      check("t1_last", 64'(log_q[i].l), 64'(i == 7));
    end

    // Back-to-back beats, second partial.
    log_q.delete();
    send(64'h1817161514131211, 8'hFF, 1'b0, 2'b00);
    send(64'h2827262524232221, 8'h07, 1'b1, 2'b00);
    drain();
    check("t2_len", 64'(log_q.size()), 64'(11));
    if (log_q.size() == 11) begin
      check("t2_b11", 64'(log_q[10].d), 64'h23);
      check("t2_l11", 64'(log_q[10].l), 64'(1));
      check("t2_l10", 64'(log_q[9].l), 64'(0));
    end

    // Sparse keep.
    log_q.delete();
    send(64'h8877665544332211, 8'hA5, 1'b1, 2'b00);
    drain();
    check("t3_len", 64'(log_q.size()), 64'(4));
    if (log_q.size() == 4) begin
      check("t3_data", 64'({log_q[0].d, log_q[1].d, log_q[2].d,
                           log_q[3].d}), 64'h11336688);
      check("t3_last", 64'(log_q[3].l), 64'(1));
    end

    // Stalling sink 1,0,0,1.
    rmode = 2;
    log_q.delete();
    send(64'h0807060504030201, 8'hFF, 1'b1, 2'b00);
    drain();
    check("t4_len", 64'(log_q.size()), 64'(8));
    for (int i = 0; i < log_q.size(); i++) begin
      check("t4_data", 64'(log_q[i].d), 64'(i + 1));
    end
    rmode = 0;

    // Error on first beat of a 3-beat frame, then a clean frame.
    log_q.delete();
    send(64'h0102030405060708, 8'hFF, 1'b0, 2'b01);
    send(64'h1112131415161718, 8'hFF, 1'b0, 2'b00);
    send(64'h2122232425262728, 8'h0F, 1'b1, 2'b00);
    send(64'h3132333435363738, 8'hFF, 1'b1, 2'b00);
    drain();
    check("t5_len", 64'(log_q.size()), 64'(28));
    for (int i = 0; i < log_q.size(); i++) begin
      check("t5_err", 64'(log_q[i].u[0]), 64'(i == 19));
    end

    // Null closing beat, then a null non-closing beat.
    log_q.delete();
    ns = null_seen;
    send(64'hDEADBEEFCAFEF00D, 8'h00, 1'b1, 2'b00);
    send(64'h1234567812345678, 8'h00, 1'b0, 2'b00);
    drain();
    check("t6_len", 64'(log_q.size()), 64'(1));
    if (log_q.size() == 1) begin
      check("t6_b", 64'({log_q[0].d, log_q[0].l, log_q[0].u[0]}),
            64'h003);
    end
    check("t6_pulses", 64'(null_seen - ns), 64'(1));

    // Reset while a beat is being held.
    rmode = 3;
    send(64'h0807060504030201, 8'hFF, 1'b1, 2'b00);
    s_tvalid = 1'b0;
    @(negedge aclk);
    check("t7_held", 64'(m_tvalid), 64'(1));
    #2 aresetn = 1'b0;
    #1;
    check("t7_rst_valid", 64'(m_tvalid), 64'(0));
    check("t7_rst_ready", 64'(s_tready), 64'(0));
    check("t7_rst_outs", 64'({m_tdata, m_tlast, m_tuser}), 64'(0));
    rmode = 0;
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("t7_ready_up", 64'(s_tready), 64'(1));
    log_q.delete();
    send(64'h00000000000000AA, 8'h01, 1'b1, 2'b00);
    drain();
    check("t7_len", 64'(log_q.size()), 64'(1));

    // Random traffic against the model.
    rmode = 1;
    for (int b = 0; b < 400; b++) begin
      logic [KW-1:0] k;
      k = KW'($urandom);
      if ($urandom_range(0, 9) == 0) k = '0;
      send({$urandom, $urandom}, k, 1'($urandom_range(0, 9) < 3),
           {1'($urandom), 1'($urandom_range(0, 9) == 0)});
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge aclk);
        #1;
      end
    end
    drain();
    rmode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
